// File: rtl/oam_dma_bridge_pkg.sv
// Shared definitions for the core/memory bus bridge and its OAM DMA engine.
//   bridge_state_t : state encoding of the DMA engine (exported for debug)
//   GB_*           : address map constants and transfer defaults
//   echo_fold()    : maps a DMA source page onto the memory it really reads
package gb_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } bridge_state_t;

    localparam logic [15:0] GB_DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] GB_OAM_BASE     = 16'hFE00;
    localparam logic [15:0] GB_HRAM_LO      = 16'hFF80;
    localparam logic [15:0] GB_HRAM_HI      = 16'hFFFE;
    localparam logic [7:0]  GB_OPEN_BUS     = 8'hFF;
    localparam int unsigned GB_DMA_LENGTH   = 160;

    // Pages E0..FF alias work RAM (echo region), so the source page drops by 0x20.
    function automatic logic [7:0] echo_fold(input logic [7:0] page);
        return (page < 8'hE0) ? page : page - 8'h20;
    endfunction

endpackage

// File: rtl/oam_dma_bridge_if.sv
// Bus bundle between the core, the bridge and the memory slaves.
//   cpu_* : core side (address, write data, active-low strobes, read data back)
//   mem_* : memory side (address, write data, active-low strobes, read data in)
// Strobe semantics: a cycle with *_nread low is a read whose data is valid by the
// end of that same cycle; a cycle with *_nwrite low commits write data at the
// rising edge closing the cycle. Both strobes high means no access. There is no
// wait state: every strobed cycle completes in exactly one clock.
// master = core + memory model (drives cpu_* requests and mem_rdata),
// slave  = bridge.
interface oam_dma_bridge_if;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_nread;
    logic        cpu_nwrite;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_nread;
    logic        mem_nwrite;

    modport master (
        output cpu_address, cpu_wdata, cpu_nread, cpu_nwrite, mem_rdata,
        input  cpu_rdata, mem_address, mem_wdata, mem_nread, mem_nwrite
    );

    modport slave (
        input  cpu_address, cpu_wdata, cpu_nread, cpu_nwrite, mem_rdata,
        output cpu_rdata, mem_address, mem_wdata, mem_nread, mem_nwrite
    );
endinterface

// File: rtl/oam_dma_bridge_engine.sv
// OAM DMA engine: state machine, byte index and read/write byte latch.
//   clock, reset       : clock, asynchronous active-low reset
//   start              : load pulse (FF46 write); (re)starts a transfer
//   stall              : core owns the bus this cycle; hold everything
//   src_hi             : source page (already echo folded)
//   mem_rdata          : memory read data, latched at the end of an RD cycle
//   req_*              : bus request the engine wants driven this cycle
//   dma_active         : transfer in progress (START, RD or WR)
//   state              : current state, exported for debug/checkers
module oam_dma_engine import gb_bus_pkg::*; #(
    parameter int unsigned DMA_LENGTH = GB_DMA_LENGTH,
    parameter logic [15:0] DST_BASE   = GB_OAM_BASE
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic [7:0]    src_hi,
    input  logic [7:0]    mem_rdata,
    output logic [15:0]   req_address,
    output logic [7:0]    req_wdata,
    output logic          req_nread,
    output logic          req_nwrite,
    output logic          dma_active,
    output bridge_state_t state
);

    localparam logic [7:0] LAST_INDEX = 8'(DMA_LENGTH - 1);

    logic [7:0] index;
    logic [7:0] latch;

    // A start pulse wins over everything else, so a restart from any state
    // lands in START with the index cleared; OAM bytes already written stay.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            index      <= 8'd0;
            latch      <= 8'd0;
            dma_active <= 1'b0;
        end else if (start) begin
            state      <= ST_START;
            index      <= 8'd0;
            dma_active <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_START: begin
                    state <= ST_RD;
                    index <= 8'd0;
                end
                ST_RD: begin
                    if (!stall) begin
                        latch <= mem_rdata;
                        state <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (!stall) begin
                        index <= index + 8'd1;
                        if (index == LAST_INDEX) begin
                            state      <= ST_IDLE;
                            dma_active <= 1'b0;
                        end else begin
                            state <= ST_RD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request is a pure decode of registered state; the top decides whether
    // it actually reaches the bus (it does not while stalled).
    always_comb begin
        req_address = {src_hi, index};
        req_wdata   = latch;
        req_nread   = 1'b1;
        req_nwrite  = 1'b1;
        case (state)
            ST_RD: begin
                req_nread = 1'b0;
            end
            ST_WR: begin
                req_address = DST_BASE + {8'h00, index};
                req_nwrite  = 1'b0;
            end
            default: begin
                req_nread  = 1'b1;
                req_nwrite = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/oam_dma_bridge.sv
// Bridge between the core memory port and the memory slaves, owning the OAM
// DMA register. Idle: core traffic passes straight through. While the DMA
// engine owns the bus, the core only reaches HRAM (which stalls the engine for
// that cycle); other core reads see open bus and other core writes are dropped.
//   clock, reset : clock, asynchronous active-low reset
//   bus          : slave side of the core/memory bus bundle
//   dma_active   : transfer in progress
//   dma_state    : engine state, exported for debug/checkers
module oam_dma_bridge import gb_bus_pkg::*; #(
    parameter logic [15:0] DMA_REG_ADDR = GB_DMA_REG_ADDR,
    parameter int unsigned DMA_LENGTH   = GB_DMA_LENGTH,
    parameter logic [15:0] DST_BASE     = GB_OAM_BASE,
    parameter logic [15:0] HRAM_LO      = GB_HRAM_LO,
    parameter logic [15:0] HRAM_HI      = GB_HRAM_HI
) (
    input  logic             clock,
    input  logic             reset,
    oam_dma_bridge_if.slave  bus,
    output logic             dma_active,
    output bridge_state_t    dma_state
);

    logic [7:0]  dma_reg;
    logic [7:0]  src_hi;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        is_reg;
    logic        in_hram;
    logic        busy;
    logic        core_fwd;
    logic        stall;
    logic        reg_wr;
    logic [15:0] req_address;
    logic [7:0]  req_wdata;
    logic        req_nread;
    logic        req_nwrite;

    // Both core strobes low is illegal; it is resolved as a write.
    assign cpu_wr  = ~bus.cpu_nwrite;
    assign cpu_rd  = ~bus.cpu_nread & bus.cpu_nwrite;
    assign is_reg  = (bus.cpu_address == DMA_REG_ADDR);
    assign in_hram = (bus.cpu_address >= HRAM_LO) && (bus.cpu_address <= HRAM_HI);
    assign reg_wr  = cpu_wr & is_reg;
    assign src_hi  = echo_fold(dma_reg);

    // START still passes core traffic through; fencing applies only once the
    // engine actually drives the bus.
    assign busy     = (dma_state == ST_RD) || (dma_state == ST_WR);
    assign core_fwd = (cpu_rd | cpu_wr) & ~is_reg & (~busy | in_hram);
    assign stall    = busy & core_fwd;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dma_reg <= 8'hFF;
        end else if (reg_wr) begin
            dma_reg <= bus.cpu_wdata;
        end
    end

    oam_dma_engine #(
        .DMA_LENGTH (DMA_LENGTH),
        .DST_BASE   (DST_BASE)
    ) u_engine (
        .clock       (clock),
        .reset       (reset),
        .start       (reg_wr),
        .stall       (stall),
        .src_hi      (src_hi),
        .mem_rdata   (bus.mem_rdata),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_nread   (req_nread),
        .req_nwrite  (req_nwrite),
        .dma_active  (dma_active),
        .state       (dma_state)
    );

    always_comb begin
        bus.mem_address = bus.cpu_address;
        bus.mem_wdata   = bus.cpu_wdata;
        bus.mem_nread   = 1'b1;
        bus.mem_nwrite  = 1'b1;
        bus.cpu_rdata   = bus.mem_rdata;

        if (core_fwd) begin
            bus.mem_nread  = ~cpu_rd;
            bus.mem_nwrite = ~cpu_wr;
        end else if (busy) begin
            bus.mem_address = req_address;
            bus.mem_wdata   = req_wdata;
            bus.mem_nread   = req_nread;
            bus.mem_nwrite  = req_nwrite;
        end

        if (is_reg) begin
            bus.cpu_rdata = dma_reg;
        end else if (busy && !in_hram) begin
            bus.cpu_rdata = GB_OPEN_BUS;
        end

        // No strobe may escape while reset is held, even if the core strobes.
        if (!reset) begin
            bus.mem_nread  = 1'b1;
            bus.mem_nwrite = 1'b1;
        end
    end

endmodule

// File: tb/tb_oam_dma_bridge.sv
module tb_oam_dma_bridge;
    import gb_bus_pkg::*;

    localparam int LEN = 160;

    logic          clock = 1'b0;
    logic          reset;
    logic          dma_active;
    bridge_state_t dma_state;

    oam_dma_bridge_if bus();

    oam_dma_bridge dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .dma_active (dma_active),
        .dma_state  (dma_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- memory model + scoreboard ----------------
    logic [7:0]  mem [0:65535];
    logic [23:0] exp_q[$];
    int          n_checks = 0;
    int          n_bad    = 0;
    int          fall_cyc = -1;
    logic        prev_active = 1'b0;

    assign bus.mem_rdata = mem[bus.mem_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clock) begin
        logic [23:0] e;
        if (!bus.mem_nwrite) begin
            if (bus.mem_address >= 16'hFE00 && bus.mem_address < 16'hFE00 + LEN) begin
                if (exp_q.size() == 0) begin
                    check("oam_unexpected", {8'h00, bus.mem_address, bus.mem_wdata}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("oam_write", {bus.mem_address, bus.mem_wdata}, e);
                end
            end
            mem[bus.mem_address] = bus.mem_wdata;
        end
    end

    always @(negedge clock) begin
        if (prev_active && !dma_active) fall_cyc = cyc;
        prev_active = dma_active;
        assert (!(bus.cpu_nread == 1'b0 && bus.cpu_nwrite == 1'b0))
            else $error("illegal core strobes driven");
        if (!bus.mem_nread && !bus.mem_nwrite) check("strobe_excl", 1, 0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #1;
    endtask

    task automatic cpu_idle();
        bus.cpu_nread  = 1'b1;
        bus.cpu_nwrite = 1'b1;
    endtask

    task automatic cpu_set(input logic [15:0] a, input logic [7:0] d, input logic wr);
        bus.cpu_address = a;
        bus.cpu_wdata   = d;
        bus.cpu_nread   = wr;
        bus.cpu_nwrite  = ~wr;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_set(a, d, 1'b1);
        sample();
        if (a == GB_DMA_REG_ADDR) check("reg_wr_hidden", bus.mem_nwrite, 1);
        tick();
        cpu_idle();
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_set(a, 8'h00, 1'b0);
        sample();
        d = bus.cpu_rdata;
        tick();
        cpu_idle();
    endtask

    function automatic logic [17:0] bus_now();
        return {bus.mem_address, bus.mem_nread, bus.mem_nwrite};
    endfunction

    // Reference rule for the source page of a transfer.
    function automatic logic [7:0] src_of(input logic [7:0] r);
        if (r >= 8'hE0) return r - 8'h20;
        return r;
    endfunction

    // Start a transfer from page r and drive it until stop_at non-stalled
    // engine cycles (2 per byte) have elapsed, injecting random core traffic.
    // Every non-HRAM cycle the bus must show the engine's read/write for the
    // current byte; every HRAM cycle pushes completion out by one.
    task automatic run_dma(input logic [7:0] r, input int noise_pct, input int stop_at);
        logic [7:0]  sh;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  old;
        logic [17:0] exp_bus;
        int          w;
        int          p;
        int          h;
        int          act;
        sh = src_of(r);
        for (int i = 0; i < stop_at / 2; i++)
            exp_q.push_back({16'(16'hFE00 + i), mem[{sh, 8'(i)}]});
        cpu_write(GB_DMA_REG_ADDR, r);
        w = cyc;
        sample();
        check("start_active", dma_active, 1);
        check("start_quiet", {bus.mem_nread, bus.mem_nwrite}, 2'b11);
        tick();
        p = 0;
        h = 0;
        while (p < stop_at) begin
            act = ($urandom_range(0, 99) < noise_pct) ? int'($urandom_range(1, 5)) : 0;
            if (p % 2 == 0) exp_bus = {sh, 8'(p / 2), 2'b01};
            else            exp_bus = {16'(16'hFE00 + p / 2), 2'b10};
            case (act)
                1: begin
                    a = $urandom_range(0, 1) ? 16'hFF90 : 16'($urandom_range(16'hFF80, 16'hFFFE));
                    cpu_set(a, 8'h00, 1'b0);
                    sample();
                    check("hram_rd_bus", bus_now(), {a, 2'b01});
                    check("hram_rd_data", bus.cpu_rdata, mem[a]);
                    tick();
                    h++;
                end
                2: begin
                    a = 16'($urandom_range(16'hFF80, 16'hFFFE));
                    d = 8'($urandom);
                    cpu_set(a, d, 1'b1);
                    sample();
                    check("hram_wr_bus", bus_now(), {a, 2'b10});
                    tick();
                    check("hram_wr_mem", mem[a], d);
                    h++;
                end
                3: begin
                    a = $urandom_range(0, 1) ? 16'h0100 : 16'($urandom_range(0, 16'hFEFF));
                    cpu_set(a, 8'h00, 1'b0);
                    sample();
                    check("fence_rd_data", bus.cpu_rdata, 8'hFF);
                    check("dma_bus", bus_now(), exp_bus);
                    tick();
                    p++;
                end
                4: begin
                    a = $urandom_range(0, 1) ? 16'hC000 : 16'($urandom_range(0, 16'h7FFF));
                    old = mem[a];
                    cpu_set(a, ~old, 1'b1);
                    sample();
                    check("dma_bus", bus_now(), exp_bus);
                    tick();
                    check("fence_wr_drop", mem[a], old);
                    p++;
                end
                5: begin
                    cpu_set(GB_DMA_REG_ADDR, 8'h00, 1'b0);
                    sample();
                    check("reg_rd_busy", bus.cpu_rdata, r);
                    check("dma_bus", bus_now(), exp_bus);
                    tick();
                    p++;
                end
                default: begin
                    sample();
                    check("dma_bus", bus_now(), exp_bus);
                    tick();
                    p++;
                end
            endcase
            cpu_idle();
        end
        if (stop_at >= 2 * LEN) begin
            sample();
            check("done_idle", dma_active, 0);
            check("latency", fall_cyc - w, 2 * LEN + 1 + h);
            for (int k = 0; k < 1000 && dma_active; k++) tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rd;
        reset = 1'b0;
        bus.cpu_address = 16'h0150;
        bus.cpu_wdata   = 8'h00;
        bus.cpu_nread   = 1'b0;
        bus.cpu_nwrite  = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        // Reset state, with the core strobing a read that must not escape.
        #12;
        check("reset_active", dma_active, 0);
        check("reset_strobes", {bus.mem_nread, bus.mem_nwrite}, 2'b11);
        check("reset_state", dma_state, ST_IDLE);
        cpu_idle();
        #10 reset = 1'b1;
        tick();
        cpu_read(GB_DMA_REG_ADDR, rd);
        check("reset_reg", rd, 8'hFF);

        // Idle pass-through read and write.
        mem[16'h0150] = 8'h3E;
        cpu_set(16'h0150, 8'h00, 1'b0);
        sample();
        check("pass_rd_bus", bus_now(), {16'h0150, 2'b01});
        check("pass_rd_data", bus.cpu_rdata, 8'h3E);
        check("pass_idle", dma_active, 0);
        tick();
        cpu_idle();
        cpu_write(16'hC000, 8'h77);
        check("pass_wr_mem", mem[16'hC000], 8'h77);

        // Basic transfer from C1 with a known pattern.
        for (int i = 0; i < LEN; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
        run_dma(8'hC1, 0, 2 * LEN);
        check("oam_first", mem[16'hFE00], 8'h5A);
        check("oam_last", mem[16'hFE9F], 8'hC5);
        cpu_read(GB_DMA_REG_ADDR, rd);
        check("reg_rd_c1", rd, 8'hC1);

        // Fencing under heavy core traffic.
        run_dma(8'hC1, 40, 2 * LEN);

        // Echo fold source.
        run_dma(8'hE3, 0, 2 * LEN);

        // Restart at byte 40 of a C1 transfer.
        run_dma(8'hC1, 0, 80);
        run_dma(8'hD0, 0, 2 * LEN);

        // Reset in the middle of a transfer (byte 80).
        run_dma(8'hC1, 0, 160);
        #2 reset = 1'b0;
        #1;
        check("abort_active", dma_active, 0);
        check("abort_strobes", {bus.mem_nread, bus.mem_nwrite}, 2'b11);
        check("abort_state", dma_state, ST_IDLE);
        tick();
        tick();
        sample();
        check("abort_quiet", {bus.mem_nread, bus.mem_nwrite, dma_active}, 3'b110);
        reset = 1'b1;
        tick();
        cpu_read(GB_DMA_REG_ADDR, rd);
        check("abort_reg", rd, 8'hFF);
        check("abort_sb", exp_q.size(), 0);

        // Random transfers with random core traffic.
        for (int t = 0; t < 4; t++) run_dma(8'($urandom_range(0, 255)), 25, 2 * LEN);

        repeat (3) tick();
        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/oam_dma_bridge.md
Name: oam_dma_bridge

Overview:
- Bus bridge between the core's memory port and the memory slaves (ROM and the rest of the memory map).
- Idle: passes core cycles straight through to memory.
- Owns the DMA register at FF46. A core write to FF46 starts an OAM DMA: the bridge becomes bus master and copies DMA_LENGTH bytes from {reg,8'h00} to DST_BASE.
- While a DMA runs, the core is fenced to HRAM only.

Parameters:
- DMA_REG_ADDR, 16'hFF46, address of the DMA source register.
- DMA_LENGTH, 160, bytes per transfer (max 256).
- DST_BASE, 16'hFE00, OAM destination base.
- HRAM_LO, 16'hFF80, lowest core-accessible address during DMA.
- HRAM_HI, 16'hFFFE, highest core-accessible address during DMA.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_address  in  16  core bus address.
- cpu_wdata  in  8  core write data.
- cpu_rdata  out  8  read data returned to core.
- cpu_nread  in  1  core read strobe, active low.
- cpu_nwrite  in  1  core write strobe, active low.
- mem_address  out  16  address to memory slaves.
- mem_wdata  out  8  write data to memory slaves.
- mem_rdata  in  8  read data from memory slaves; valid by the end of a cycle with mem_nread low.
- mem_nread  out  1  memory read strobe, active low.
- mem_nwrite  out  1  memory write strobe, active low.
- dma_active  out  1  high while a transfer is in progress.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, dma_reg=8'hFF, index=0, byte latch=0, dma_active=0.
  - mem_nread=mem_nwrite=1.
- cpu_nread and cpu_nwrite both low is illegal. Treat it as a write; the bench asserts it never occurs.
- FF46 access:
  - Write: latches cpu_wdata into dma_reg and is never forwarded (mem_nwrite stays 1).
  - Read: cpu_rdata=dma_reg, mem_nread stays 1.
  - Both are legal in any state.
- Source base: src_hi = dma_reg if dma_reg<8'hE0, else dma_reg-8'h20 (echo fold).
- States:
  - IDLE: full combinational pass-through. mem_* = cpu_*; cpu_rdata=mem_rdata (except FF46). A FF46 write goes to START at the next edge.
  - START: one dead cycle; the bus passes core traffic as in IDLE. Next state RD, index=0.
  - RD: mem_address={src_hi,index}, mem_nread=0. At the edge, latch mem_rdata, go to WR.
  - WR: mem_address=DST_BASE+index, mem_wdata=latch, mem_nwrite=0. At the edge, index+1. If index==DMA_LENGTH-1, go to IDLE; else go to RD.
- dma_active=1 in START, RD and WR.
- Transfer latency: FF46 write edge -> 1 START + 2*DMA_LENGTH cycles (321 for defaults) with no stalls.
- Core fencing while dma_active (RD/WR):
  - Core access in [HRAM_LO,HRAM_HI]: forwarded to memory this cycle. The DMA stalls, holding state, index and latch, and drives no strobes.
  - Other core read: cpu_rdata=8'hFF, no memory cycle.
  - Other core write: dropped.
  - FF46 access: handled per the FF46 rule, with no stall.
- Restart: a FF46 write in START/RD/WR loads the new dma_reg and goes to START; index resets to 0. A partially written OAM is left as is.
- Index width: 8 bits, compared against DMA_LENGTH-1; no wrap beyond DMA_LENGTH.
- Mid-transfer reset: abort immediately to reset values; no further memory strobes.
- Strobe exclusivity: mem_nread and mem_nwrite are never both 0.

Decomposition:
- Shared package gb_bus_pkg holds:
  - the bridge state enum (IDLE, START, RD, WR);
  - address constants (DMA_REG_ADDR, HRAM_LO/HI, OAM base FE00);
  - the open-bus value 8'hFF.
- Natural sub-module: oam_dma_engine, holding the state machine, index counter and byte latch. It outputs its bus request and accepts a stall input.
- The top level keeps the FF46 register, core fence and output mux.

Test Plan:
- Pass-through idle: core read at 16'h0150 with ROM byte 8'h3E -> mem_address=0150, mem_nread=0, cpu_rdata=3E same cycle; dma_active=0.
- Basic DMA:
  - Core writes 8'hC1 to FF46 with C100..C19F = i^8'h5A.
  - Expected: dma_active rises next cycle; first RD at C100 two cycles after the write edge; WR to FE00 with 8'h5A.
  - FE9F ends as 8'hC5; dma_active falls exactly 321 cycles after the write edge.
  - FF46 reads back C1.
- Fencing:
  - During DMA, core read 0x0100 -> cpu_rdata=FF with no mem strobe.
  - Core write C000 -> dropped (memory unchanged).
  - Core read FF90 -> forwarded, and the DMA index holds that cycle (completion pushed out 1 cycle per HRAM access).
- Echo fold: write 8'hE3 to FF46 -> reads come from C300..C39F.
- Restart: write 8'hD0 at byte 40 of a C1 transfer -> next RD at D000 after one START cycle; FE00.. rewritten from D0 data; total 321 cycles from the second write.
- Reset mid-transfer: pull reset low at byte 80 -> same cycle dma_active=0, mem_nread=mem_nwrite=1, FF46 reads FF after release.
